seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with dead-time blanking and frame-synchronous double buffering.
// Define LZ_SUPPRESS_EN to blank leading zeros of the committed value.
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int ON_CYCLES    = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] digits_in,
   input  logic [DIGITS-1:0]   dp_in,
   output logic [6:0]          seg_n,
   output logic                dp_n,
   output logic [DIGITS-1:0]   an_n,
   output logic                frame_tick
);
   localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   typedef enum logic {S_BLANK, S_ON} state_t;
   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
   logic                pending_q, pending_d;
   logic [6:0]          seg_n_q, seg_n_d;
   logic                dp_n_q, dp_n_d;
   logic [DIGITS-1:0]   an_n_q, an_n_d;
   logic                frame_tick_q, frame_tick_d;
   logic [DIGITS-1:0]   blank_mask;
   logic                blank_last, on_last, wrap, lit;
   logic [3:0]          cur_code;
   logic                cur_dp;
`ifdef LZ_SUPPRESS_EN
   logic                zeros_above;
`endif
   function automatic logic [6:0] glyph(input logic [3:0] c);
      case (c)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
   endfunction
   always_comb begin
      blank_last   = (state_q == S_BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
      on_last      = (state_q == S_ON) && (cnt_q == CW'(ON_CYCLES - 1));
      wrap         = on_last && (idx_q == IW'(DIGITS - 1));
      state_d      = blank_last ? S_ON : on_last ? S_BLANK : state_q;
      cnt_d        = (blank_last || on_last) ? '0 : cnt_q + 1'b1;
      idx_d        = wrap ? '0 : on_last ? idx_q + 1'b1 : idx_q;
      shadow_d     = load ? digits_in : shadow_q;
      shadow_dp_d  = load ? dp_in : shadow_dp_q;
      // A load landing on the commit edge bypasses the shadow so it is not lost for a frame.
      disp_d       = (wrap && load) ? digits_in : (wrap && pending_q) ? shadow_q : disp_q;
      disp_dp_d    = (wrap && load) ? dp_in : (wrap && pending_q) ? shadow_dp_q : disp_dp_q;
      pending_d    = wrap ? 1'b0 : load ? 1'b1 : pending_q;
      frame_tick_d = wrap;
   end
   always_comb begin
      blank_mask = '0;
`ifdef LZ_SUPPRESS_EN
      zeros_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zeros_above   = zeros_above && (disp_d[4*i +: 4] == 4'd0);
         blank_mask[i] = zeros_above && !disp_dp_d[i];
      end
`endif
   end
   // Outputs are registered from next-state values so they line up with the current state/idx.
   always_comb begin
      lit      = en && (state_d == S_ON);
      cur_code = disp_d[4*idx_d +: 4];
      cur_dp   = disp_dp_d[idx_d];
      an_n_d   = lit ? ~(DIGITS'(1) << idx_d) : '1;
      seg_n_d  = (lit && !blank_mask[idx_d]) ? glyph(cur_code) : 7'h7F;
      dp_n_d   = !(lit && cur_dp);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         disp_q       <= '0;
         disp_dp_q    <= '0;
         pending_q    <= 1'b0;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         an_n_q       <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_q       <= disp_d;
         disp_dp_q    <= disp_dp_d;
         pending_q    <= pending_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end
   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign frame_tick = frame_tick_q;
endmodule
